// File: rtl/usart_pkg.sv
// Shared definitions for the USART family: receiver state encoding,
// baud divisor helper and default parameter values.
package usart_pkg;

  localparam int DEF_CLK_FREQ  = 100000000;
  localparam int DEF_BAUD_RATE = 115200;
  localparam int DEF_DATA_BIT  = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/usart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops
// load RESET_VAL while reset is low.
module usart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/usart_rx.sv
// Asynchronous serial receiver: mid-bit sampling FSM feeding a one-entry
// holding register with valid/ack handshake, framing error and overrun pulses.
//
// state        | meaning
// RX_IDLE      | line idle, waiting for a low on rx_s
// RX_START     | half-bit wait, then confirm the start bit is still low
// RX_DATA      | sample DATA_BIT data bits at mid-bit, LSB first
// RX_STOP      | sample the stop bit at mid-bit
// RX_WAIT_IDLE | after a framing error, wait for the line to return high
module usart_rx
  import usart_pkg::*;
#(
  parameter int CLK_FREQ  = DEF_CLK_FREQ,
  parameter int BAUD_RATE = DEF_BAUD_RATE,
  parameter int DATA_BIT  = DEF_DATA_BIT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rx,
  input  logic                rx_ack,
  output logic [DATA_BIT-1:0] rx_data,
  output logic                rx_valid,
  output logic                frame_err,
  output logic                overrun,
  output logic                busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic                rx_s;
  rx_state_t           state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [2:0]          bit_idx, bit_idx_nxt;
  logic [DATA_BIT-1:0] shift_q, shift_nxt;
  logic                frame_ok, frame_bad;
  logic                done_ok_q, done_bad_q;

  usart_sync2 #(.RESET_VAL(1'b1)) u_sync_rx (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift_q <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift_q <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift_q;
    frame_ok    = 1'b0;
    frame_bad   = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = RX_START;
      end
      RX_START: begin
        if (cnt == CNT_W'(HALF_BIT - 1)) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_nxt            = '0;
          shift_nxt[bit_idx] = rx_s;
          if (bit_idx == 3'(DATA_BIT - 1)) state_nxt = RX_STOP;
          else bit_idx_nxt = bit_idx + 3'd1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_nxt = '0;
          if (rx_s) begin
            frame_ok  = 1'b1;
            state_nxt = RX_IDLE;
          end else begin
            frame_bad = 1'b1;
            state_nxt = RX_WAIT_IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RX_WAIT_IDLE: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = RX_IDLE;
      end
      default: state_nxt = RX_IDLE;
    endcase
  end

  // Frame outcome is staged one cycle before it reaches the holding register;
  // shift_q cannot change in that cycle because the FSM is back in IDLE/WAIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      done_ok_q  <= 1'b0;
      done_bad_q <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done_ok_q  <= frame_ok;
      done_bad_q <= frame_bad;
      frame_err  <= done_bad_q;
      overrun    <= 1'b0;
      if (done_ok_q) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
        overrun  <= rx_valid && !rx_ack;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != RX_IDLE);

endmodule

// File: tb/tb_usart_rx.sv
// Directed bench for usart_rx at 16 clocks per bit: frame timing, glitch
// reject, framing error, overrun, ack/completion collision and mid-frame reset.
module tb_usart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, busy;

  int total = 0;
  int bad   = 0;

  int edge_n;
  int ack_edge;
  int valid_at, ferr_cnt, ferr_at, ovr_cnt, ovr_at;
  logic valid_prev, busy_seen;

  usart_rx #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BIT(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .rx_ack   (rx_ack),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    rx_ack = (ack_edge >= 0) && (edge_n + 1 == ack_edge);
    @(posedge clk);
    #1;
    edge_n++;
    if (rx_valid && !valid_prev && valid_at < 0) valid_at = edge_n;
    valid_prev = rx_valid;
    if (frame_err) begin ferr_cnt++; ferr_at = edge_n; end
    if (overrun) begin ovr_cnt++; ovr_at = edge_n; end
    if (busy) busy_seen = 1'b1;
  endtask

  task automatic clear_mon();
    edge_n     = -1;
    valid_at   = -1;
    ferr_cnt   = 0;
    ferr_at    = -1;
    ovr_cnt    = 0;
    ovr_at     = -1;
    valid_prev = rx_valid;
    busy_seen  = 1'b0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_ack();
    ack_edge = edge_n + 1;
    step();
    ack_edge = -1;
  endtask

  // Drives nsteps edges of a frame; edge 0 (T0) is the first with rx low.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len,
                            input int nsteps);
    clear_mon();
    for (int k = 0; k < nsteps; k++) begin
      if (k < 16) rx = 1'b0;
      else if (k < 144) rx = b[(k - 16) / 16];
      else if (k < 144 + stop_len) rx = stop_v;
      else rx = 1'b1;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; rx = 1'b1; rx_ack = 1'b0; ack_edge = -1;
    clear_mon();
    for (int i = 0; i < 3; i++) step();
    total++;
    if ({rx_valid, frame_err, overrun, busy} !== 4'b0000 || rx_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b ferr=%b ovr=%b busy=%b data=%h, need all 0",
               rx_valid, frame_err, overrun, busy, rx_data);
    end
    reset = 1'b1;
    idle(10);
    total++;
    if (busy !== 1'b0 || rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b valid=%b, need 0 0", busy, rx_valid);
    end
  endtask

  task automatic test_single_frame();
    send_frame(8'hA5, 1'b1, 16, 160);
    total++;
    if (valid_at !== 155) begin
      bad++; $display("FAIL a5_latency: got %0d need 155", valid_at);
    end
    total++;
    if (rx_data !== 8'hA5 || rx_valid !== 1'b1) begin
      bad++; $display("FAIL a5_data: data=%h valid=%b need a5 1", rx_data, rx_valid);
    end
    total++;
    if (ferr_cnt !== 0 || ovr_cnt !== 0) begin
      bad++; $display("FAIL a5_flags: ferr=%0d ovr=%0d need 0 0", ferr_cnt, ovr_cnt);
    end
    idle(3);
    do_ack();
    total++;
    if (rx_valid !== 1'b0) begin
      bad++; $display("FAIL ack_clears: valid=%b need 0", rx_valid);
    end
    do_ack();
    total++;
    if (rx_valid !== 1'b0 || rx_data !== 8'hA5) begin
      bad++; $display("FAIL ack_idle_ignored: valid=%b data=%h need 0 a5", rx_valid, rx_data);
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx = 1'b0;
    for (int i = 0; i < 5; i++) step();
    idle(30);
    total++;
    if (busy_seen !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL glitch_reject: busy_seen=%b busy=%b need 1 0", busy_seen, busy);
    end
    total++;
    if (rx_valid !== 1'b0 || ferr_cnt !== 0) begin
      bad++; $display("FAIL glitch_flags: valid=%b ferr=%0d need 0 0", rx_valid, ferr_cnt);
    end
  endtask

  task automatic test_frame_err();
    send_frame(8'h3C, 1'b0, 32, 176);
    idle(20);
    total++;
    if (ferr_cnt !== 1 || ferr_at !== 155) begin
      bad++; $display("FAIL ferr_pulse: count=%0d at=%0d need 1 155", ferr_cnt, ferr_at);
    end
    total++;
    if (rx_valid !== 1'b0 || rx_data !== 8'hA5 || busy !== 1'b0) begin
      bad++; $display("FAIL ferr_discard: valid=%b data=%h busy=%b need 0 a5 0",
                      rx_valid, rx_data, busy);
    end
    send_frame(8'h11, 1'b1, 16, 160);
    total++;
    if (rx_data !== 8'h11 || valid_at !== 155 || ferr_cnt !== 0) begin
      bad++; $display("FAIL after_ferr: data=%h valid_at=%0d ferr=%0d need 11 155 0",
                      rx_data, valid_at, ferr_cnt);
    end
    do_ack();
  endtask

  task automatic test_overrun();
    send_frame(8'h01, 1'b1, 16, 160);
    send_frame(8'h02, 1'b1, 16, 160);
    total++;
    if (ovr_cnt !== 1 || ovr_at !== 155) begin
      bad++; $display("FAIL overrun_pulse: count=%0d at=%0d need 1 155", ovr_cnt, ovr_at);
    end
    total++;
    if (rx_data !== 8'h02 || rx_valid !== 1'b1) begin
      bad++; $display("FAIL overrun_data: data=%h valid=%b need 02 1", rx_data, rx_valid);
    end
    do_ack();
  endtask

  task automatic test_ack_collision();
    send_frame(8'h55, 1'b1, 16, 160);
    ack_edge = 155;
    send_frame(8'h7E, 1'b1, 16, 160);
    ack_edge = -1;
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h7E || ovr_cnt !== 0) begin
      bad++; $display("FAIL ack_collision: valid=%b data=%h ovr=%0d need 1 7e 0",
                      rx_valid, rx_data, ovr_cnt);
    end
  endtask

  task automatic test_mid_reset();
    send_frame(8'h5A, 1'b1, 16, 88);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL midframe_busy: busy=%b need 1", busy);
    end
    reset = 1'b0;
    rx = 1'b1;
    step();
    total++;
    if ({rx_valid, frame_err, overrun, busy} !== 4'b0000 || rx_data !== 8'h00) begin
      bad++; $display("FAIL midframe_reset: valid=%b ferr=%b ovr=%b busy=%b data=%h need 0",
                      rx_valid, frame_err, overrun, busy, rx_data);
    end
    reset = 1'b1;
    idle(40);
    total++;
    if (rx_valid !== 1'b0 || ferr_cnt !== 0 || ovr_cnt !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL post_reset_quiet: valid=%b ferr=%0d ovr=%0d busy=%b need 0",
                      rx_valid, ferr_cnt, ovr_cnt, busy);
    end
    send_frame(8'hC3, 1'b1, 16, 160);
    total++;
    if (rx_data !== 8'hC3 || valid_at !== 155) begin
      bad++; $display("FAIL post_reset_frame: data=%h valid_at=%0d need c3 155",
                      rx_data, valid_at);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_ack_collision();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usart_rx.md
# usart_rx

Serial receiver for the USART block family, the receive end of the existing transmitter on the same link. It recovers asynchronous 8N1-style frames from a single serial input using the same clock/baud parameterisation, and presents each byte through a one-entry holding register with a valid/acknowledge handshake. It flags framing errors and overruns. It sits between the board RX pin and the consumer logic, for example a command parser or FIFO.

## Interface
- `CLK_FREQ`, default 100000000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in bit/s.
- `DATA_BIT`, default 8: data bits per frame, valid range 5..8.
- Derived `CLKS_PER_BIT` = `CLK_FREQ/BAUD_RATE` (integer division). `HALF_BIT` = `CLKS_PER_BIT/2`.
- `clk`  in  1  the only clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `rx`  in  1  asynchronous serial line; idles high.
- `rx_data`  out  `DATA_BIT`  last received byte, LSB = first data bit on the line.
- `rx_valid`  out  1  holding register is full; held until acknowledged.
- `rx_ack`  in  1  consumer pulse; clears `rx_valid`.
- `frame_err`  out  1  one-cycle pulse: the stop bit was sampled low.
- `overrun`  out  1  one-cycle pulse: a new byte was written while `rx_valid` = 1 and no ack arrived.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Input conditioning: a 2-flop synchronizer drives `rx_s`. Both flops reset to 1. All decisions use `rx_s` only.
- The FSM has five states: IDLE, START, DATA, STOP and WAIT_IDLE.
- The bit-timer counter is sized to hold `CLKS_PER_BIT`-1. The bit index counter is 3 bits wide.
- IDLE:
  - Counter held at 0.
  - `rx_s` = 0 → START.
- START:
  - The counter runs to `HALF_BIT`-1, then `rx_s` is sampled.
  - Sample 0 → DATA, with counter and bit index cleared.
  - Sample 1 → IDLE. This is a glitch reject; no flag is raised.
- DATA:
  - The counter runs to `CLKS_PER_BIT`-1, then `rx_s` is shifted into the shift register LSB-first at position index.
  - After bit `DATA_BIT`-1 is sampled → STOP.
- STOP:
  - After `CLKS_PER_BIT` cycles, `rx_s` is sampled.
  - Sample 1 → byte transferred to `rx_data`, `rx_valid` set → IDLE.
  - Sample 0 → `frame_err` pulses, the byte is discarded and `rx_data`/`rx_valid` are unchanged → WAIT_IDLE.
- WAIT_IDLE: stays until `rx_s` = 1, then → IDLE. This prevents a break condition from being decoded as back-to-back start bits.
- Handshake:
  - `rx_ack` while `rx_valid` = 1 clears `rx_valid` on the next edge.
  - `rx_ack` while `rx_valid` = 0 is ignored.
  - `rx_data` is stable while `rx_valid` = 1, except on overrun.
- Overrun: a byte completes while `rx_valid` = 1 and `rx_ack` = 0. The new byte overwrites `rx_data`, `rx_valid` stays 1, and `overrun` pulses.
- Simultaneous completion and `rx_ack`: the new byte is loaded, `rx_valid` stays 1, and there is no overrun.

## Timing
- Values at reset (`reset` = 0 at a clock edge):
  - FSM = IDLE, all counters = 0.
  - `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0.
  - Synchronizer flops = 1.
- Reset mid-frame aborts the frame immediately. No flag is raised and nothing is written to `rx_data`.
- Clock-level timing:
  - `rx` is first low at clock edge T0 (sampled into sync flop 1). `rx_s` is low after T0+1 and START is entered at T0+2.
  - `rx_valid` rises exactly 2 + `HALF_BIT` + (`DATA_BIT`+1)·`CLKS_PER_BIT` + 1 cycles after T0.
  - `frame_err` rises at the same cycle offset in the error case.
- Every data and stop sample lands `HALF_BIT` cycles after the nominal bit start, i.e. at mid-bit.
- The next start bit is accepted on the first cycle back in IDLE, so back-to-back frames with one stop bit are received without loss.
- `frame_err` and `overrun` are registered and last exactly one cycle.

## Structure
- A shared `usart_pkg` holds:
  - FSM state encoding (`rx_state_t`).
  - A `clks_per_bit(CLK_FREQ, BAUD_RATE)` function, also to be used by the transmitter.
  - Default parameter constants.
- One sub-module, `usart_sync2`: a 2-flop synchronizer with a parameterised reset value. It is reused for any other asynchronous input in the family.
- The FSM, counters, shift register and holding register stay in `usart_rx`.

## Test plan
All scenarios use `CLK_FREQ`=16, `BAUD_RATE`=1, so `CLKS_PER_BIT`=16 and `HALF_BIT`=8.
- Frame for 0xA5 (start, 1,0,1,0,0,1,0,1, stop) → `rx_valid` rises 155 cycles after T0, `rx_data` = 0xA5, no flags.
- Low glitch of 5 cycles on an idle line → FSM returns to IDLE, `rx_valid` stays 0, no `frame_err`.
- Frame for 0x3C with stop bit held 0 for 32 cycles → `frame_err` pulses once, `rx_valid` stays 0, and the next valid frame 0x11 is received correctly.
- Frames 0x01 then 0x02 with no `rx_ack` → `overrun` pulses once, `rx_data` = 0x02, `rx_valid` = 1.
- `rx_ack` asserted on the exact cycle a second byte 0x7E completes → `rx_valid` stays 1, `rx_data` = 0x7E, `overrun` stays 0.
- `reset` = 0 in the middle of data bit 4 → all outputs return to reset values the next cycle, and a following frame 0xC3 is received correctly.
